// File: rtl/apple1_uart_pkg.sv
// rtl/apple1_uart_pkg.sv - shared types and constants for the apple1 host-side UART
package apple1_uart_pkg;

  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Rounded clock cycles per bit.
  function automatic int baud_div(input int clk, input int baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous show-ahead byte queue feeding the transmitter
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;

  // Pointers carry one extra wrap bit so full and empty differ.
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_full    = (o_count == FULL_COUNT);
  assign o_empty   = (o_count == '0);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

endmodule

// File: rtl/apple1_uart_host.sv
// rtl/apple1_uart_host.sv - host terminal endpoint: queued 8N1 transmitter with CTS and 8N1 receiver
module apple1_uart_host
  import apple1_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       i_clk25,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_host_txd,
  input  logic       i_host_cts,
  input  logic       i_host_rxd,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_frame_err,
  output logic       o_busy
);

  localparam int DIV      = baud_div(CLK_FREQ, BAUD);
  localparam int HALF     = DIV / 2;
  localparam int CW       = $clog2(DIV + 1);
  localparam int FAW      = $clog2(FIFO_DEPTH);
  localparam int LAST_BIT = FRAME_BITS - 3;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(LAST_BIT);

  logic [7:0]   w_fifo_rd_data;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic [FAW:0] w_fifo_count;
  logic         w_tx_pop;

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk     (i_clk25),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (i_tx_valid),
    .i_wr_data (i_tx_data),
    .i_rd_en   (w_tx_pop),
    .o_rd_data (w_fifo_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_txd, w_txd_nxt;
  logic          r_cts_meta, r_cts_sync;
  logic          w_tx_go;

  assign w_tx_go    = !w_fifo_empty && r_cts_sync;
  assign o_tx_ready = !w_fifo_full;
  assign o_host_txd = r_txd;
  assign o_busy     = (r_tx_state != TX_IDLE) || (w_fifo_count != '0);

  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= IDLE_LEVEL;
      r_cts_meta <= 1'b0;
      r_cts_sync <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_cts_meta <= i_host_cts;
      r_cts_sync <= r_cts_meta;
    end
  end

  // The line is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_pop       = 1'b0;
    w_txd_nxt      = IDLE_LEVEL;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tx_go) begin
          w_tx_pop       = 1'b1;
          w_tx_shift_nxt = w_fifo_rd_data;
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        w_txd_nxt = 1'b0;
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = TX_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        w_txd_nxt = r_tx_shift[0];
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          if (r_tx_bit == BIT_LAST) w_tx_state_nxt = TX_STOP;
          else                      w_tx_bit_nxt   = r_tx_bit + 1'b1;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt = '0;
          // Chain straight into the next start bit so queued bytes go out gap-free.
          if (w_tx_go) begin
            w_tx_pop       = 1'b1;
            w_tx_shift_nxt = w_fifo_rd_data;
            w_tx_state_nxt = TX_START;
          end else begin
            w_tx_state_nxt = TX_IDLE;
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic [7:0]    r_rx_data, w_rx_data_nxt;
  logic          r_rx_valid, w_rx_valid_nxt;
  logic          r_rx_ferr, w_rx_ferr_nxt;
  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic          w_rx_fall;

  assign w_rx_fall      = r_rx_prev && !r_rx_sync;
  assign o_rx_data      = r_rx_data;
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_frame_err = r_rx_ferr;

  always_ff @(posedge i_clk25 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_meta  <= IDLE_LEVEL;
      r_rx_sync  <= IDLE_LEVEL;
      r_rx_prev  <= IDLE_LEVEL;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_ferr  <= w_rx_ferr_nxt;
      r_rx_meta  <= i_host_rxd;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_rx_ferr_nxt  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_fall) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        // A line that is high again at mid-start was only a glitch.
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_bit_nxt = '0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_bit == BIT_LAST) w_rx_state_nxt = RX_STOP;
          else                      w_rx_bit_nxt   = r_rx_bit + 1'b1;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          if (r_rx_sync) begin
            w_rx_data_nxt  = r_rx_shift;
            w_rx_valid_nxt = 1'b1;
          end else begin
            w_rx_ferr_nxt = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apple1_uart_host.sv
// tb/tb_apple1_uart_host.sv - self-checking bench for apple1_uart_host at DIV = 25
module tb_apple1_uart_host;

  localparam int DIV   = 25;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       host_cts = 1'b1;
  logic       drv_rxd = 1'b1;
  logic       lb = 1'b0;
  logic       tx_ready, host_txd, host_rxd, rx_valid, rx_frame_err, busy;
  logic [7:0] rx_data;

  assign host_rxd = lb ? host_txd : drv_rxd;

  apple1_uart_host #(
    .CLK_FREQ   (25000000),
    .BAUD       (1000000),
    .FIFO_DEPTH (16)
  ) dut (
    .i_clk25        (clk),
    .i_rst_n        (rst_n),
    .i_tx_data      (tx_data),
    .i_tx_valid     (tx_valid),
    .o_tx_ready     (tx_ready),
    .o_host_txd     (host_txd),
    .i_host_cts     (host_cts),
    .i_host_rxd     (host_rxd),
    .o_rx_data      (rx_data),
    .o_rx_valid     (rx_valid),
    .o_rx_frame_err (rx_frame_err),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         start_cyc[$];
  int         frames = 0;
  bit         in_frame = 1'b0;
  int         pos = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] last_good = 8'h00;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    bit acc;
    tx_data  = b;
    tx_valid = 1'b1;
    acc = (tx_q.size() < 16);
    tick(1);
    tx_valid = 1'b0;
    if (acc) begin
      tx_q.push_back(b);
      if (lb) rx_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || in_frame) && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  task automatic wait_busy_low(input string name, input int budget, output int at);
    int n = 0;
    while (busy && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, n < budget, 1);
    at = cyc;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drv_rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      drv_rxd = b[i];
      tick(DIV);
    end
    drv_rxd = stop;
    tick(DIV);
    drv_rxd = 1'b1;
  endtask

  // Line model: every frame must carry the oldest queued byte as 0, b[0..7], 1.
  initial forever begin
    int bitn;
    logic expb;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      in_frame = 1'b0;
      tx_q.delete();
      chk("txd_in_reset", host_txd, 1);
    end else if (!in_frame) begin
      if (host_txd == 1'b0) begin
        chk("tx_frame_expected", tx_q.size() != 0, 1);
        cur = (tx_q.size() != 0) ? tx_q.pop_front() : 8'h00;
        in_frame = 1'b1;
        pos = 1;
        start_cyc.push_back(cyc);
        frames++;
      end
    end else begin
      bitn = pos / DIV;
      expb = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : cur[bitn-1];
      chk("tx_line", host_txd, expb);
      pos++;
      if (pos == FRAME) in_frame = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      rx_q.delete();
      last_good = 8'h00;
    end else begin
      if (rx_valid) begin
        chk("rx_valid_expected", rx_q.size() != 0, 1);
        if (rx_q.size() != 0) last_good = rx_q.pop_front();
        valid_cnt++;
      end
      if (rx_frame_err) ferr_cnt++;
      chk("rx_data", rx_data, last_good);
      chk("rx_pulse_exclusive", rx_valid && rx_frame_err, 0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [0:9] a5_bits;
    int w, f0, v0, e0, at, n;
    a5_bits = 10'b0101001011;

    tick(3);
    chk("rst_txd", host_txd, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_frame_err", rx_frame_err, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(4);

    wr(8'hA5);
    w = cyc;
    chk("a5_busy_after_write", busy, 1);
    tick(1);
    chk("a5_line_still_idle", host_txd, 1);
    tick(1);
    chk("a5_start_fall_2cyc", host_txd, 0);
    tick(DIV / 2);
    for (int i = 0; i < 10; i++) begin
      chk("a5_mid_bit", host_txd, a5_bits[i]);
      if (i < 9) tick(DIV);
    end
    wait_busy_low("a5_busy_timeout", 400, at);
    chk("a5_busy_drop_cycle", at - w, 1 + FRAME);
    wait_drain("a5_drain", 100);

    host_cts = 1'b0;
    tick(4);
    f0 = frames;
    wr(8'h8D);
    wr(8'hC1);
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      chk("fc_hold_line", host_txd, 1);
    end
    chk("fc_held_frames", frames - f0, 0);
    host_cts = 1'b1;
    wait_busy_low("fc_busy_timeout", 1000, at);
    wait_drain("fc_drain", 300);
    chk("fc_frames_sent", frames - f0, 2);
    chk("fc_back_to_back", start_cyc[f0+1] - start_cyc[f0], FRAME);
    chk("fc_total_500", at - start_cyc[f0], 2 * FRAME - 1);

    host_cts = 1'b0;
    tick(4);
    f0 = frames;
    wr(8'h8D);
    wr(8'hC1);
    tick(20);
    host_cts = 1'b1;
    wait_frames("fcm_first_start", f0 + 1, 50);
    tick(100);
    host_cts = 1'b0;
    tick(300);
    chk("fcm_one_frame_only", frames - f0, 1);
    chk("fcm_second_held", tx_q.size(), 1);
    chk("fcm_line_idle", host_txd, 1);
    chk("fcm_busy_while_held", busy, 1);
    host_cts = 1'b1;
    wait_drain("fcm_drain", 400);
    chk("fcm_frames_sent", frames - f0, 2);

    host_cts = 1'b0;
    tick(4);
    f0 = frames;
    for (int i = 0; i <= 16; i++) begin
      wr(8'(i));
      chk("ff_tx_ready", tx_ready, (i < 15) ? 1 : 0);
    end
    tick(50);
    chk("ff_no_output_while_held", frames - f0, 0);
    host_cts = 1'b1;
    wait_drain("ff_drain", 4500);
    chk("ff_frames_sent", frames - f0, 16);
    chk("ff_ready_after_drain", tx_ready, 1);

    lb = 1'b1;
    tick(2);
    v0 = valid_cnt;
    e0 = ferr_cnt;
    wr(8'hD2);
    wr(8'h00);
    wr(8'hFF);
    wait_drain("lb_drain", 1000);
    n = 0;
    while (rx_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    tick(DIV);
    chk("lb_valid_pulses", valid_cnt - v0, 3);
    chk("lb_no_frame_err", ferr_cnt - e0, 0);
    chk("lb_last_byte", rx_data, 8'hFF);
    lb = 1'b0;
    tick(4);

    v0 = valid_cnt;
    e0 = ferr_cnt;
    drv_rxd = 1'b0;
    tick(5);
    drv_rxd = 1'b1;
    tick(100);
    chk("glitch_no_valid", valid_cnt - v0, 0);
    chk("glitch_no_ferr", ferr_cnt - e0, 0);
    send_frame(8'h41, 1'b0);
    tick(60);
    chk("ferr_one_pulse", ferr_cnt - e0, 1);
    chk("ferr_no_valid", valid_cnt - v0, 0);
    chk("ferr_data_kept", rx_data, 8'hFF);
    rx_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    tick(60);
    chk("rx_good_after_ferr", valid_cnt - v0, 1);
    chk("rx_good_data", rx_data, 8'h3C);

    f0 = frames;
    wr(8'h55);
    wait_frames("rst_frame_start", f0 + 1, 50);
    tick(4 * DIV + DIV / 2);
    chk("rst_line_low_at_bit3", host_txd, 0);
    #2 rst_n = 1'b0;
    #1 chk("rst_txd_async", host_txd, 1);
    tick(2);
    chk("rst_mid_tx_ready", tx_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    tick(600);
    chk("rst_nothing_after", frames - f0, 1);
    chk("rst_line_idle", host_txd, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
